axis_hdr_insert_gen2: RTL
=========================

Name: axis_hdr_insert_gen2

Overview:
- Parametrised successor to the single-width AXI-Stream header inserter.
- Prepends a header of 1..NB bytes to every packet and repacks the data so the output stream is contiguous and MSB-lane-first.
- Header and last-beat byte counts may take any value; there is no minimum combined byte count.
- Headers are queued in a small FIFO so back-to-back packets run without idle cycles. Sits between the packet source and the downstream AXIS sink.

Parameters:
DATA_WD, 32, data bus width in bits; must be a multiple of 8.
NB, DATA_WD/8, bytes per beat (derived; do not override).
HDR_DEPTH, 2, header FIFO depth; power of 2, at least 1.

Ports:
r_sys_clk  in  1  clock
r_sys_rstn  in  1  reset; asynchronous, active-low
valid_in  in  1  input data valid
data_in  in  DATA_WD  input data; lane NB-1 (MSB) is first in stream order
keep_in  in  NB  input byte enables; MSB-aligned contiguous
last_in  in  1  final beat of input packet
ready_in  out  1  input ready
valid_out  out  1  output valid
data_out  out  DATA_WD  output data
keep_out  out  NB  output byte enables; MSB-aligned contiguous
last_out  out  1  final beat of output packet
ready_out  in  1  downstream ready
valid_insert  in  1  header valid
data_insert  in  DATA_WD  header bytes, LSB-aligned
keep_insert  in  NB  header enables; LSB-aligned contiguous (0001..1111 for NB=4)
ready_insert  out  1  header FIFO not full
err_keep  out  1  sticky protocol-error flag

Behaviour:
- Reset (r_sys_rstn low, asynchronous): all outputs 0, FIFO emptied, state IDLE. Applies mid-packet too; the partial packet is discarded.
- Header FIFO: writes on valid_insert && ready_insert. Stores data plus H = trailing-ones count of keep_insert.
- Output register: updates only when !valid_out || ready_out. While valid_out && !ready_out, data/keep/last are held stable.
- Latency: one cycle from an input or header accept to the corresponding output beat.
- Residue register: holds R bytes, 0..NB, MSB-aligned.
- Each combined output beat = residue (R bytes) followed by the top NB-R bytes of data_in. The new residue is the remaining bytes of that input beat.
- FSM states:
  - IDLE: waits for the FIFO to be non-empty. Pops the header into the residue, R = H. If H == NB, go to HFULL, else go to BODY.
  - HFULL: emits the header as a full beat, keep all ones. Go to BODY with R = 0 (passthrough).
  - BODY: ready_in = output register free. Let L be the byte count of the accepted beat.
    - Non-last beat: emit combined beat, keep all ones.
    - Last beat with R+L <= NB: emit final beat, keep = top R+L ones, last_out = 1. Go to IDLE, or pop the next header in the same cycle if the FIFO is non-empty (no bubble).
    - Last beat with R+L > NB: emit a full beat. Go to FLUSH with residue R+L-NB.
  - FLUSH: ready_in = 0. Emit the residue, keep = top ones, last_out = 1. Next state follows the IDLE/pop rule.
- Output beat count per packet = ceil((H + total data bytes)/NB).
- ready_in = 0 in IDLE, HFULL and FLUSH. Data is never accepted before its header.
- err_keep is set and held until reset on any of:
  - non-contiguous keep_in or keep_insert;
  - keep_in != all ones on a non-last beat (the beat is treated as all ones);
  - keep_insert == 0 (treated as H = 1).
- Width rules: byte counts are $clog2(NB)+1 bits. Shifts are by whole bytes.

Decomposition:
- Package axis_hdr_pkg: function for leading-ones count (MSB side), function for trailing-ones count, function for contiguity check, function for count-to-keep mask, FSM state enum (IDLE, HFULL, BODY, FLUSH).
- Sub-module axis_hdr_fifo: synchronous FIFO, depth HDR_DEPTH, width DATA_WD + count width, with full/empty flags.

Test Plan:
- NB=4, H=3 (header 0x555555, keep_insert 0111), 8 beats from 0x10203040 incrementing 0x01010101, last keep 1000 (29 data bytes) -> 8 output beats; beat0 0x55555510 keep 1111; beat1 0x20304011; last beat keep 1111 with last_out.
- NB=4, H=1 (0x000000AA), one data beat 0x11223344 keep 1111 last -> 0xAA112233 keep 1111, then FLUSH beat 0x44xxxxxx keep 1000 last_out.
- NB=4, H=4 (0xDEADBEEF), 2 beats -> header beat 0xDEADBEEF keep 1111, then data passthrough unchanged; 3 beats total.
- Two packets back-to-back with both headers preloaded, ready_out = 1 -> valid_out stays high continuously across the packet boundary.
- ready_out random 50% -> data/keep/last stable while stalled; byte sequence identical to the ready_out = 1 run.
- Non-last beat keep 1100 -> err_keep = 1 and stays 1. Reset mid-packet -> outputs 0; next packet correct.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared helpers for the AXIS header inserter.
// Purpose: keep-mask byte counting, contiguity check, count-to-mask, FSM states.
// Masks are passed zero-extended to MAX_NB bits, and nb gives the live width.
package axis_hdr_pkg;
  localparam int MAX_NB = 64;

  typedef enum logic [1:0] {IDLE, HFULL, BODY, FLUSH} hdr_st_e;

  // Run of ones starting at lane nb-1 and going down.
  function automatic int lead_ones(input logic [MAX_NB-1:0] k, input int nb);
    int n;
    logic run;
    n = 0;
    run = 1'b1;
    for (int i = MAX_NB-1; i >= 0; i--)
      if (i < nb) begin
        if (run && k[i]) n = n + 1;
        else run = 1'b0;
      end
    return n;
  endfunction

  // Run of ones starting at lane 0 and going up.
  function automatic int trail_ones(input logic [MAX_NB-1:0] k, input int nb);
    int n;
    logic run;
    n = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_NB; i++)
      if (i < nb) begin
        if (run && k[i]) n = n + 1;
        else run = 1'b0;
      end
    return n;
  endfunction

  // Top cnt lanes of an nb-lane mask set.
  function automatic logic [MAX_NB-1:0] top_mask(input int cnt, input int nb);
    logic [MAX_NB-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_NB; i++)
      if (i < nb && i >= nb - cnt) m[i] = 1'b1;
    return m;
  endfunction

  // True when k is a single run anchored at the MSB lane (msb_side) or at lane 0.
  function automatic logic is_contig(input logic [MAX_NB-1:0] k, input int nb,
                                     input logic msb_side);
    logic [MAX_NB-1:0] m;
    int t;
    m = '0;
    t = trail_ones(k, nb);
    if (msb_side) m = top_mask(lead_ones(k, nb), nb);
    else
      for (int i = 0; i < MAX_NB; i++)
        if (i < t) m[i] = 1'b1;
    return m == k;
  endfunction
endpackage

// File: rtl/axis_hdr_fifo.sv
// Header FIFO: first-word fall-through, DEPTH entries of WIDTH bits.
// Ports: i_wr/i_wdata push (ignored when full), i_rd pop (ignored when empty),
//        o_rdata head entry, o_full / o_empty flags.
module axis_hdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             r_sys_clk,
  input  logic             r_sys_rstn,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CNTW-1:0]  r_cnt;
  logic             w_wr, w_rd;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_full  = (r_cnt == CNTW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge r_sys_clk or negedge r_sys_rstn)
    if (!r_sys_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= inc(r_wptr);
      if (w_rd) r_rptr <= inc(r_rptr);
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
    end

  always_ff @(posedge r_sys_clk)
    if (w_wr) r_mem[r_wptr] <= i_wdata;
endmodule

// File: rtl/axis_hdr_insert_gen2.sv
// AXIS header inserter: prepends a 1..NB byte header to every packet and repacks
// the stream so output beats are contiguous, MSB lane first.
// Ports: valid_in/data_in/keep_in/last_in/ready_in  packet input (keep MSB-aligned)
//        valid_insert/data_insert/keep_insert/ready_insert  header input (LSB-aligned)
//        valid_out/data_out/keep_out/last_out/ready_out  registered output stream
//        err_keep  sticky flag for malformed keep patterns
module axis_hdr_insert_gen2
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD   = 32,
  parameter int NB        = DATA_WD / 8,
  parameter int HDR_DEPTH = 2
) (
  input  logic               r_sys_clk,
  input  logic               r_sys_rstn,
  input  logic               valid_in,
  input  logic [DATA_WD-1:0] data_in,
  input  logic [NB-1:0]      keep_in,
  input  logic               last_in,
  output logic               ready_in,
  output logic               valid_out,
  output logic [DATA_WD-1:0] data_out,
  output logic [NB-1:0]      keep_out,
  output logic               last_out,
  input  logic               ready_out,
  input  logic               valid_insert,
  input  logic [DATA_WD-1:0] data_insert,
  input  logic [NB-1:0]      keep_insert,
  output logic               ready_insert,
  output logic               err_keep
);
  localparam int CW  = $clog2(NB) + 1;
  localparam int CW1 = CW + 1;
  localparam int FW  = DATA_WD + CW;

  function automatic logic [DATA_WD-1:0] kexp(input logic [NB-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  hdr_st_e            r_state, w_nstate, w_after;
  logic               r_live, r_valid, r_last, r_err;
  logic [DATA_WD-1:0] r_data, r_res;
  logic [NB-1:0]      r_keep;
  logic [CW-1:0]      r_rcnt;

  // ---- header FIFO ----
  logic               w_fwr, w_pop, w_full, w_empty, w_hdr_full;
  logic [CW-1:0]      w_hcnt_in, w_hdr_cnt;
  logic [DATA_WD-1:0] w_hdr_data, w_hdr_al;
  logic [FW-1:0]      w_fdout;
  logic [MAX_NB-1:0]  w_kins_x, w_kin_x;

  assign w_kins_x = MAX_NB'(keep_insert);
  // An empty header mask still yields a one-byte header so the packet is not lost.
  assign w_hcnt_in = (keep_insert == '0) ? CW'(1) : CW'(trail_ones(w_kins_x, NB));
  // r_live keeps ready_insert low while reset is held.
  assign ready_insert = r_live && !w_full;
  assign w_fwr = valid_insert && ready_insert;

  axis_hdr_fifo #(.WIDTH(FW), .DEPTH(HDR_DEPTH)) u_fifo (
    .r_sys_clk  (r_sys_clk),
    .r_sys_rstn (r_sys_rstn),
    .i_wr       (w_fwr),
    .i_wdata    ({data_insert, w_hcnt_in}),
    .i_rd       (w_pop),
    .o_rdata    (w_fdout),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign w_hdr_data = w_fdout[FW-1:CW];
  assign w_hdr_cnt  = w_fdout[CW-1:0];
  assign w_hdr_full = (w_hdr_cnt == CW'(NB));
  // Header bytes move from LSB lanes to MSB lanes to become the residue.
  assign w_hdr_al   = w_hdr_data << (8 * (NB - int'(w_hdr_cnt)));

  // ---- beat accounting ----
  logic          w_free, w_acc, w_fits, w_done, w_ld, w_nl, w_res_ld, w_err_set;
  logic [CW-1:0] w_L, w_over, w_nrcnt;
  logic [CW:0]   w_sum;
  logic [NB-1:0] w_m_sum, w_m_over, w_m_res, w_kout, w_kres, w_nk;
  logic [DATA_WD-1:0] w_nd, w_nres;

  assign w_free   = !r_valid || ready_out;
  assign ready_in = (r_state == BODY) && w_free;
  assign w_acc    = valid_in && ready_in;
  assign w_kin_x  = MAX_NB'(keep_in);
  // Non-last beats always count as full, whatever keep_in says.
  assign w_L      = last_in ? CW'(lead_ones(w_kin_x, NB)) : CW'(NB);
  assign w_sum    = {1'b0, r_rcnt} + {1'b0, w_L};
  assign w_fits   = (w_sum <= CW1'(NB));
  assign w_over   = CW'(w_sum - CW1'(NB));
  assign w_m_sum  = NB'(top_mask(int'(w_sum), NB));
  assign w_m_over = NB'(top_mask(int'(w_over), NB));
  assign w_m_res  = NB'(top_mask(int'(r_rcnt), NB));
  assign w_kout   = (last_in && w_fits) ? w_m_sum : '1;
  assign w_kres   = last_in ? w_m_over : '1;

  // A packet ends on a fitting last beat or on the flush beat; the next header
  // pops in that same cycle so back-to-back packets carry no bubble.
  assign w_done = (w_acc && last_in && w_fits) || ((r_state == FLUSH) && w_free);
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_done);
  assign w_after = w_pop ? (w_hdr_full ? HFULL : BODY) : IDLE;

  assign w_err_set = (w_acc && (!is_contig(w_kin_x, NB, 1'b1) || (!last_in && keep_in != '1)))
                  || (w_fwr && (keep_insert == '0 || !is_contig(w_kins_x, NB, 1'b0)));

  // ---- FSM: state register ----
  always_ff @(posedge r_sys_clk or negedge r_sys_rstn)
    if (!r_sys_rstn) r_state <= IDLE;
    else             r_state <= w_nstate;

  // ---- FSM: next state ----
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    w_nstate = w_after;
      HFULL:   if (w_free) w_nstate = BODY;
      BODY:    if (w_acc && last_in) w_nstate = w_fits ? w_after : FLUSH;
      FLUSH:   if (w_free) w_nstate = w_after;
      default: w_nstate = IDLE;
    endcase
  end

  // ---- FSM: outputs / datapath controls ----
  always_comb begin
    w_ld     = 1'b0;
    w_nd     = r_data;
    w_nk     = r_keep;
    w_nl     = r_last;
    w_res_ld = 1'b0;
    w_nres   = r_res;
    w_nrcnt  = r_rcnt;
    case (r_state)
      HFULL: if (w_free) begin
        w_ld = 1'b1; w_nd = r_res; w_nk = '1; w_nl = 1'b0;
        w_res_ld = 1'b1; w_nres = '0; w_nrcnt = '0;
      end
      BODY: if (w_acc) begin
        // residue bytes on top, then the leading input bytes beneath them
        w_ld = 1'b1;
        w_nd = (r_res | (data_in >> (8 * int'(r_rcnt)))) & kexp(w_kout);
        w_nk = w_kout;
        w_nl = last_in && w_fits;
        w_res_ld = 1'b1;
        w_nres = (data_in << (8 * (NB - int'(r_rcnt)))) & kexp(w_kres);
        w_nrcnt = !last_in ? r_rcnt : (w_fits ? '0 : w_over);
      end
      FLUSH: if (w_free) begin
        w_ld = 1'b1; w_nd = r_res; w_nk = w_m_res; w_nl = 1'b1;
        w_res_ld = 1'b1; w_nres = '0; w_nrcnt = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge r_sys_clk or negedge r_sys_rstn)
    if (!r_sys_rstn) begin
      r_live  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_res   <= '0;
      r_rcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_ld) begin
        r_valid <= 1'b1;
        r_data  <= w_nd;
        r_keep  <= w_nk;
        r_last  <= w_nl;
      end else if (ready_out) begin
        r_valid <= 1'b0;
      end
      if (w_pop) begin
        r_res  <= w_hdr_al;
        r_rcnt <= w_hdr_cnt;
      end else if (w_res_ld) begin
        r_res  <= w_nres;
        r_rcnt <= w_nrcnt;
      end
      if (w_err_set) r_err <= 1'b1;
    end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign keep_out  = r_keep;
  assign last_out  = r_last;
  assign err_keep  = r_err;
endmodule
